// File: rtl/rs_param_pkg.sv
// rtl/rs_param_pkg.sv - shared widths, defaults and ROB age helper for the reservation station
package rs_param_pkg;

    localparam int OPCODE_W   = 7;
    localparam int FUNC3_W    = 3;
    localparam int FUNC7_W    = 1;
    localparam int ROB_W_DEF  = 4;
    localparam int DATA_W_DEF = 32;

    // Widest ROB position the age helper supports.
    localparam int AGE_W_MAX  = 16;

    // Distance of pos from head walking forward around the ROB ring.
    // Smaller means older; the ROB head itself has age 0.
    function automatic logic [AGE_W_MAX-1:0] rob_age(
        input logic [AGE_W_MAX-1:0] pos,
        input logic [AGE_W_MAX-1:0] head,
        input int unsigned          w
    );
        logic [AGE_W_MAX-1:0] mask;
        mask = (AGE_W_MAX'(1) << w) - AGE_W_MAX'(1);
        return (pos - head) & mask;
    endfunction

endpackage

// File: rtl/rs_age_select.sv
// rtl/rs_age_select.sv - pick the oldest ready slot from a ready vector and an age array
// Ports: ready (per-slot candidate flag), age (per-slot age, smaller is older),
//        idx (winning slot), found (any candidate present).
module rs_age_select
    import rs_param_pkg::*;
#(
    parameter int N     = 16,
    parameter int AGE_W = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]            ready,
    input  logic [N-1:0][AGE_W-1:0] age,
    output logic [IDX_W-1:0]        idx,
    output logic                    found
);

    // Pairwise reduction: after the pass with stride s, slot i (a multiple
    // of 2s) holds the winner of slots i .. i+2s-1. Ties keep the lower slot.
    always_comb begin
        logic [N-1:0]     v;
        logic [AGE_W-1:0] a  [N];
        logic [IDX_W-1:0] ix [N];
        for (int i = 0; i < N; i++) begin
            v[i]  = ready[i];
            a[i]  = age[i];
            ix[i] = IDX_W'(i);
        end
        for (int s = 1; s < N; s = s * 2) begin
            for (int i = 0; i < N; i = i + 2 * s) begin
                if (v[i+s] && (!v[i] || a[i+s] < a[i])) begin
                    v[i]  = 1'b1;
                    a[i]  = a[i+s];
                    ix[i] = ix[i+s];
                end
            end
        end
        found = v[0];
        idx   = ix[0];
    end

endmodule

// File: rtl/rs_param.sv
// rtl/rs_param.sv - parametrised ALU reservation station with CDB snooping and age-ordered dispatch
// Ports: clk/rst (sync, active-high), rdy (global enable), rollback (flush),
//        rob_head (oldest ROB position), full, issue + issue_* (new entry fields),
//        cdb_valid/cdb_rob_pos/cdb_val (packed broadcast channels, channel 0 in LSBs),
//        alu_valid/alu_ready + alu_* (registered dispatch payload).
module rs_param
    import rs_param_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int NUM_CDB = 2,
    parameter int ROB_W   = ROB_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      rollback,
    input  logic [ROB_W-1:0]          rob_head,
    output logic                      full,
    input  logic                      issue,
    input  logic [ROB_W-1:0]          issue_rob_pos,
    input  logic [OPCODE_W-1:0]       issue_opcode,
    input  logic [FUNC3_W-1:0]        issue_func3,
    input  logic [FUNC7_W-1:0]        issue_func7,
    input  logic [DATA_W-1:0]         issue_imm,
    input  logic [DATA_W-1:0]         issue_pc,
    input  logic                      issue_rs1_busy,
    input  logic [ROB_W-1:0]          issue_rs1_tag,
    input  logic [DATA_W-1:0]         issue_rs1_val,
    input  logic                      issue_rs2_busy,
    input  logic [ROB_W-1:0]          issue_rs2_tag,
    input  logic [DATA_W-1:0]         issue_rs2_val,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0]  cdb_rob_pos,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_val,
    output logic                      alu_valid,
    input  logic                      alu_ready,
    output logic [OPCODE_W-1:0]       alu_opcode,
    output logic [FUNC3_W-1:0]        alu_func3,
    output logic [FUNC7_W-1:0]        alu_func7,
    output logic [DATA_W-1:0]         alu_val1,
    output logic [DATA_W-1:0]         alu_val2,
    output logic [DATA_W-1:0]         alu_imm,
    output logic [DATA_W-1:0]         alu_pc,
    output logic [ROB_W-1:0]          alu_rob_pos
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Entry storage; p1/p2 are the per-operand pending flags.
    logic [DEPTH-1:0]    busy, p1, p2;
    logic [ROB_W-1:0]    rob [DEPTH];
    logic [ROB_W-1:0]    t1  [DEPTH];
    logic [ROB_W-1:0]    t2  [DEPTH];
    logic [DATA_W-1:0]   v1  [DEPTH];
    logic [DATA_W-1:0]   v2  [DEPTH];
    logic [DATA_W-1:0]   imm [DEPTH];
    logic [DATA_W-1:0]   pc  [DEPTH];
    logic [OPCODE_W-1:0] opc [DEPTH];
    logic [FUNC3_W-1:0]  f3  [DEPTH];
    logic [FUNC7_W-1:0]  f7  [DEPTH];

    // Returns {hit, value} for a tag; scanning high to low lets the lowest
    // channel index win if two channels ever carry the same tag.
    function automatic logic [DATA_W:0] snoop(input logic [ROB_W-1:0] tag);
        logic [DATA_W:0] r;
        r = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && cdb_rob_pos[k*ROB_W +: ROB_W] == tag)
                r = {1'b1, cdb_val[k*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    logic [DEPTH-1:0]  w1_hit, w2_hit;
    logic [DATA_W-1:0] w1_val [DEPTH];
    logic [DATA_W-1:0] w2_val [DEPTH];
    logic              c1_hit, c2_hit;
    logic [DATA_W-1:0] c1_val, c2_val;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            {w1_hit[i], w1_val[i]} = snoop(t1[i]);
            {w2_hit[i], w2_val[i]} = snoop(t2[i]);
        end
        {c1_hit, c1_val} = snoop(issue_rs1_tag);
        {c2_hit, c2_val} = snoop(issue_rs2_tag);
    end

    // Lowest free slot and free-slot count.
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [CNT_W-1:0] free_cnt;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        free_cnt   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
                free_cnt   = free_cnt + CNT_W'(1);
            end
        end
    end

    // Uses the pre-edge count, so a slot freed by this cycle's dispatch is
    // not counted until next cycle.
    assign full = (free_cnt == '0) || (free_cnt == CNT_W'(1) && issue);

    logic [DEPTH-1:0]            ready;
    logic [DEPTH-1:0][ROB_W-1:0] age;

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            age[i] = ROB_W'(rob_age(AGE_W_MAX'(rob[i]), AGE_W_MAX'(rob_head), ROB_W));
    end

    assign ready = busy & ~p1 & ~p2;

    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             dispatch;

    rs_age_select #(
        .N     (DEPTH),
        .AGE_W (ROB_W)
    ) u_sel (
        .ready (ready),
        .age   (age),
        .idx   (sel_idx),
        .found (sel_found)
    );

    assign dispatch = sel_found && (!alu_valid || alu_ready);

    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            busy        <= '0;
            alu_valid   <= 1'b0;
            alu_opcode  <= '0;
            alu_func3   <= '0;
            alu_func7   <= '0;
            alu_val1    <= '0;
            alu_val2    <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
            alu_rob_pos <= '0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && p1[i] && w1_hit[i]) begin
                    p1[i] <= 1'b0;
                    v1[i] <= w1_val[i];
                end
                if (busy[i] && p2[i] && w2_hit[i]) begin
                    p2[i] <= 1'b0;
                    v2[i] <= w2_val[i];
                end
            end
            // The free slot is never busy, so it cannot collide with wakeup or dispatch.
            if (issue && free_found) begin
                busy[free_idx] <= 1'b1;
                rob[free_idx]  <= issue_rob_pos;
                opc[free_idx]  <= issue_opcode;
                f3[free_idx]   <= issue_func3;
                f7[free_idx]   <= issue_func7;
                imm[free_idx]  <= issue_imm;
                pc[free_idx]   <= issue_pc;
                t1[free_idx]   <= issue_rs1_tag;
                t2[free_idx]   <= issue_rs2_tag;
                p1[free_idx]   <= issue_rs1_busy && !c1_hit;
                p2[free_idx]   <= issue_rs2_busy && !c2_hit;
                v1[free_idx]   <= (issue_rs1_busy && c1_hit) ? c1_val : issue_rs1_val;
                v2[free_idx]   <= (issue_rs2_busy && c2_hit) ? c2_val : issue_rs2_val;
            end
            if (dispatch) begin
                busy[sel_idx] <= 1'b0;
                alu_valid     <= 1'b1;
                alu_opcode    <= opc[sel_idx];
                alu_func3     <= f3[sel_idx];
                alu_func7     <= f7[sel_idx];
                alu_val1      <= v1[sel_idx];
                alu_val2      <= v2[sel_idx];
                alu_imm       <= imm[sel_idx];
                alu_pc        <= pc[sel_idx];
                alu_rob_pos   <= rob[sel_idx];
            end else if (alu_ready) begin
                alu_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rs_param.sv
// tb/tb_rs_param.sv - self-checking bench for rs_param: vector table, corner sequences, random vs model
module tb_rs_param;

    localparam int DEPTH = 4;

    logic        clk, rst, rdy, rollback, full, issue;
    logic [3:0]  rob_head, issue_rob_pos, issue_rs1_tag, issue_rs2_tag;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_func3;
    logic        issue_func7, issue_rs1_busy, issue_rs2_busy;
    logic [31:0] issue_imm, issue_pc, issue_rs1_val, issue_rs2_val;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_rob_pos;
    logic [63:0] cdb_val;
    logic        alu_valid, alu_ready;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_func3;
    logic        alu_func7;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
    logic [3:0]  alu_rob_pos;

    rs_param #(.DEPTH(DEPTH), .NUM_CDB(2), .ROB_W(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .rob_head(rob_head), .full(full),
        .issue(issue), .issue_rob_pos(issue_rob_pos), .issue_opcode(issue_opcode),
        .issue_func3(issue_func3), .issue_func7(issue_func7), .issue_imm(issue_imm), .issue_pc(issue_pc),
        .issue_rs1_busy(issue_rs1_busy), .issue_rs1_tag(issue_rs1_tag), .issue_rs1_val(issue_rs1_val),
        .issue_rs2_busy(issue_rs2_busy), .issue_rs2_tag(issue_rs2_tag), .issue_rs2_val(issue_rs2_val),
        .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_opcode(alu_opcode), .alu_func3(alu_func3),
        .alu_func7(alu_func7), .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm),
        .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic        func7;
        logic [31:0] val1;
        logic [31:0] val2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
    } out_t;

    typedef struct {
        logic [3:0] rob; logic [6:0] op; logic [2:0] f3; logic f7; logic [31:0] imm; logic [31:0] pc;
        logic p1; logic [3:0] t1; logic [31:0] v1;
        logic p2; logic [3:0] t2; logic [31:0] v2;
    } ent_t;

    typedef struct {
        logic [3:0] rob; logic [6:0] op; logic [2:0] f3; logic f7; logic [31:0] imm; logic [31:0] pc;
        logic b1; logic [3:0] t1; logic [31:0] v1;
        logic b2; logic [3:0] t2; logic [31:0] v2;
        logic cv; logic [3:0] ctag; logic [31:0] cval;
        logic [31:0] e1; logic [31:0] e2;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: an unordered pool of waiting instructions plus the output register.
    ent_t mq[$];
    logic m_valid;
    out_t m_out;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic out_t dut_out();
        out_t o;
        o.opcode = alu_opcode; o.func3 = alu_func3; o.func7 = alu_func7;
        o.val1 = alu_val1; o.val2 = alu_val2; o.imm = alu_imm; o.pc = alu_pc; o.rob = alu_rob_pos;
        return o;
    endfunction

    function automatic int age_of(input logic [3:0] p);
        return (int'(p) - int'(rob_head) + 16) % 16;
    endfunction

    function automatic bit cdb_hit(input logic [3:0] tag, output logic [31:0] val);
        val = '0;
        for (int k = 0; k < 2; k++) begin
            if (cdb_valid[k] && cdb_rob_pos[k*4 +: 4] == tag) begin
                val = cdb_val[k*32 +: 32];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit rob_used(input logic [3:0] r);
        foreach (mq[i]) if (mq[i].rob == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_full();
        int f;
        f = DEPTH - mq.size();
        return (f == 0) || (f == 1 && issue);
    endfunction

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int best;
        logic [31:0] v;
        ent_t e;
        if (rst || rollback) begin
            mq.delete();
            m_valid = 1'b0;
            m_out = '0;
            return;
        end
        if (!rdy) return;
        best = -1;
        foreach (mq[i])
            if (!mq[i].p1 && !mq[i].p2 && (best < 0 || age_of(mq[i].rob) < age_of(mq[best].rob)))
                best = i;
        if (best >= 0 && (!m_valid || alu_ready)) begin
            e = mq[best];
            m_out.opcode = e.op; m_out.func3 = e.f3; m_out.func7 = e.f7; m_out.val1 = e.v1;
            m_out.val2 = e.v2; m_out.imm = e.imm; m_out.pc = e.pc; m_out.rob = e.rob;
            m_valid = 1'b1;
            mq.delete(best);
        end else if (alu_ready) begin
            m_valid = 1'b0;
        end
        foreach (mq[i]) begin
            if (mq[i].p1 && cdb_hit(mq[i].t1, v)) begin mq[i].p1 = 1'b0; mq[i].v1 = v; end
            if (mq[i].p2 && cdb_hit(mq[i].t2, v)) begin mq[i].p2 = 1'b0; mq[i].v2 = v; end
        end
        if (issue) begin
            e.rob = issue_rob_pos; e.op = issue_opcode; e.f3 = issue_func3; e.f7 = issue_func7;
            e.imm = issue_imm; e.pc = issue_pc;
            e.t1 = issue_rs1_tag; e.p1 = issue_rs1_busy; e.v1 = issue_rs1_val;
            e.t2 = issue_rs2_tag; e.p2 = issue_rs2_busy; e.v2 = issue_rs2_val;
            if (e.p1 && cdb_hit(e.t1, v)) begin e.p1 = 1'b0; e.v1 = v; end
            if (e.p2 && cdb_hit(e.t2, v)) begin e.p2 = 1'b0; e.v2 = v; end
            mq.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; issue = 1'b0; cdb_valid = '0;
        cdb_rob_pos = '0; cdb_val = '0; alu_ready = 1'b1; rob_head = '0;
        step();
        step();
        rst = 1'b0;
        mq.delete();
        m_valid = 1'b0;
        m_out = '0;
    endtask

    task automatic set_issue(input logic [3:0] r, input logic b1, input logic [3:0] t1,
                             input logic [31:0] v1, input logic b2, input logic [3:0] t2,
                             input logic [31:0] v2);
        issue = 1'b1; issue_rob_pos = r; issue_opcode = 7'b0110011; issue_func3 = 3'd0;
        issue_func7 = 1'b0; issue_imm = 32'h0; issue_pc = {24'h0, 4'h4, r};
        issue_rs1_busy = b1; issue_rs1_tag = t1; issue_rs1_val = v1;
        issue_rs2_busy = b2; issue_rs2_tag = t2; issue_rs2_val = v2;
    endtask

    vec_t vecs[5];

    initial begin
        out_t exp;
        int r;

        vecs[0] = '{4'd3, 7'b0110011, 3'd0, 1'b0, 32'h0, 32'h100, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7,
                    1'b0, 4'd0, 32'h0, 32'd5, 32'd7};
        vecs[1] = '{4'd5, 7'b0010011, 3'd1, 1'b0, 32'h20, 32'h104, 1'b0, 4'd0, 32'h11, 1'b1, 4'd2, 32'hBAD,
                    1'b1, 4'd2, 32'd9, 32'h11, 32'd9};
        vecs[2] = '{4'd8, 7'b0110011, 3'd5, 1'b1, 32'h0, 32'h108, 1'b1, 4'd12, 32'h1234, 1'b0, 4'd0, 32'h77,
                    1'b1, 4'd12, 32'hCAFE, 32'hCAFE, 32'h77};
        vecs[3] = '{4'd15, 7'b0110011, 3'd7, 1'b0, 32'hFFFF_FFF0, 32'h10C, 1'b1, 4'd7, 32'h1, 1'b1, 4'd7, 32'h2,
                    1'b1, 4'd7, 32'h55, 32'h55, 32'h55};
        vecs[4] = '{4'd0, 7'b0010011, 3'd2, 1'b0, 32'h3, 32'h110, 1'b0, 4'd4, 32'hAA, 1'b0, 4'd0, 32'hBB,
                    1'b1, 4'd4, 32'h99, 32'hAA, 32'hBB};

        do_reset();
        chk("reset_valid", 160'(alu_valid), 160'(0));
        chk("reset_payload", 160'(dut_out()), 160'(0));
        chk("reset_full", 160'(full), 160'(0));

        // Single-instruction vectors: operands ready, captured at issue, or unrelated broadcast.
        for (int n = 0; n < 5; n++) begin
            do_reset();
            set_issue(vecs[n].rob, vecs[n].b1, vecs[n].t1, vecs[n].v1, vecs[n].b2, vecs[n].t2, vecs[n].v2);
            issue_opcode = vecs[n].op; issue_func3 = vecs[n].f3; issue_func7 = vecs[n].f7;
            issue_imm = vecs[n].imm; issue_pc = vecs[n].pc;
            cdb_valid = {1'b0, vecs[n].cv}; cdb_rob_pos = {4'd0, vecs[n].ctag}; cdb_val = {32'd0, vecs[n].cval};
            step();
            issue = 1'b0; cdb_valid = '0;
            chk($sformatf("vec%0d_early", n), 160'(alu_valid), 160'(0));
            step();
            chk($sformatf("vec%0d_valid", n), 160'(alu_valid), 160'(1));
            exp.opcode = vecs[n].op; exp.func3 = vecs[n].f3; exp.func7 = vecs[n].f7;
            exp.val1 = vecs[n].e1; exp.val2 = vecs[n].e2; exp.imm = vecs[n].imm;
            exp.pc = vecs[n].pc; exp.rob = vecs[n].rob;
            chk($sformatf("vec%0d_payload", n), 160'(dut_out()), 160'(exp));
        end

        // Wakeup on channel 1: dispatch visible two cycles after the broadcast.
        do_reset();
        set_issue(4'd2, 1'b1, 4'd6, 32'h0, 1'b0, 4'd0, 32'd3);
        step();
        issue = 1'b0;
        step();
        chk("wake_idle", 160'(alu_valid), 160'(0));
        cdb_valid = 2'b10; cdb_rob_pos = {4'd6, 4'd0}; cdb_val = {32'hDEAD, 32'h0};
        step();
        cdb_valid = '0;
        chk("wake_not_same_cycle", 160'(alu_valid), 160'(0));
        step();
        chk("wake_valid", 160'(alu_valid), 160'(1));
        chk("wake_val1", 160'(alu_val1), 160'(32'hDEAD));
        chk("wake_val2", 160'(alu_val2), 160'(32'd3));

        // Age order across ROB wrap: head 14, both entries woken together.
        do_reset();
        rob_head = 4'd14;
        set_issue(4'd1, 1'b1, 4'd9, 32'h0, 1'b0, 4'd0, 32'h1);
        step();
        set_issue(4'd15, 1'b1, 4'd9, 32'h0, 1'b0, 4'd0, 32'h2);
        step();
        issue = 1'b0;
        cdb_valid = 2'b01; cdb_rob_pos = {4'd0, 4'd9}; cdb_val = {32'h0, 32'h42};
        step();
        cdb_valid = '0;
        step();
        chk("age_first_valid", 160'(alu_valid), 160'(1));
        chk("age_first_rob", 160'(alu_rob_pos), 160'(15));
        step();
        chk("age_second_rob", 160'(alu_rob_pos), 160'(1));
        chk("age_second_val1", 160'(alu_val1), 160'(32'h42));
        step();
        chk("age_drain", 160'(alu_valid), 160'(0));

        // Backpressure until the station is full, then one dispatch per cycle.
        do_reset();
        alu_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_issue(4'(k), 1'b0, 4'd0, 32'(100 + k), 1'b0, 4'd0, 32'(200 + k));
            #1;
            if (k == 3) chk("bp_full_free2", 160'(full), 160'(0));
            if (k == 4) chk("bp_full_last_issue", 160'(full), 160'(1));
            step();
        end
        issue = 1'b0;
        #1;
        chk("bp_full", 160'(full), 160'(1));
        chk("bp_hold_rob", 160'(alu_rob_pos), 160'(0));
        step();
        chk("bp_stable_rob", 160'(alu_rob_pos), 160'(0));
        chk("bp_stable_val1", 160'(alu_val1), 160'(100));
        chk("bp_stable_full", 160'(full), 160'(1));
        alu_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            step();
            chk($sformatf("bp_drain%0d_rob", k), 160'(alu_rob_pos), 160'(k));
            chk($sformatf("bp_drain%0d_valid", k), 160'(alu_valid), 160'(1));
            if (k == 1) chk("bp_full_drop", 160'(full), 160'(0));
        end
        step();
        chk("bp_empty", 160'(alu_valid), 160'(0));

        // Rollback with three waiting entries, a valid output and a same-cycle issue.
        do_reset();
        alu_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_issue(4'(k), 1'b0, 4'd0, 32'(k), 1'b0, 4'd0, 32'(k));
            step();
        end
        chk("rb_pre_valid", 160'(alu_valid), 160'(1));
        set_issue(4'd9, 1'b0, 4'd0, 32'h9, 1'b0, 4'd0, 32'h9);
        rollback = 1'b1;
        step();
        rollback = 1'b0; issue = 1'b0;
        #1;
        chk("rb_valid", 160'(alu_valid), 160'(0));
        chk("rb_payload", 160'(dut_out()), 160'(0));
        chk("rb_full", 160'(full), 160'(0));
        alu_ready = 1'b1;
        step();
        step();
        chk("rb_discarded", 160'(alu_valid), 160'(0));

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rdy = ($urandom_range(7) != 0);
            rollback = ($urandom_range(63) == 0);
            rob_head = 4'($urandom);
            alu_ready = ($urandom_range(2) != 0);
            cdb_valid = 2'($urandom);
            cdb_rob_pos = {4'($urandom_range(7)), 4'($urandom_range(7))};
            if (cdb_rob_pos[7:4] == cdb_rob_pos[3:0]) cdb_rob_pos[7:4] = cdb_rob_pos[3:0] + 4'd1;
            cdb_val = {$urandom, $urandom};
            issue = 1'b0;
            if (mq.size() < DEPTH && $urandom_range(1) == 1) begin
                do r = $urandom_range(15); while (rob_used(4'(r)));
                set_issue(4'(r), 1'($urandom), 4'($urandom_range(7)), $urandom,
                          1'($urandom), 4'($urandom_range(7)), $urandom);
                issue_opcode = 7'($urandom); issue_func3 = 3'($urandom); issue_func7 = 1'($urandom);
                issue_imm = $urandom; issue_pc = $urandom;
            end
            assert (!(issue && mq.size() >= DEPTH));
            #1;
            chk($sformatf("rnd%0d_full", c), 160'(full), 160'(exp_full()));
            model_step();
            step();
            chk($sformatf("rnd%0d_valid", c), 160'(alu_valid), 160'(m_valid));
            chk($sformatf("rnd%0d_payload", c), 160'(dut_out()), 160'(m_out));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_param.md
# rs_param

Parametrised reservation station for the ALU path, sitting between the decoder/issue stage and the ALU. It holds issued instructions until both source operands are available, snoops `NUM_CDB` broadcast channels for results, and dispatches the oldest ready entry (by ROB age relative to the ROB head) through a valid/ready output register. It adds configurable depth and broadcast-port count, issue-cycle operand capture, age-ordered selection and ALU backpressure.

## Interface
- `DEPTH`, 16: number of entries; power of two, minimum 2.
- `NUM_CDB`, 2: broadcast channels snooped (ALU, LSB, ...); minimum 1.
- `ROB_W`, 4: ROB position width.
- `DATA_W`, 32: operand, immediate and PC width.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable; when low, no state changes.
- `rollback` in 1: flush all entries and the output register.
- `rob_head` in ROB_W: ROB position of the oldest in-flight instruction.
- `full` out 1: combinational; 1 when free entries == 0, or free == 1 and `issue` == 1.
- `issue` in 1: write a new entry this cycle.
- `issue_rob_pos` in ROB_W, `issue_opcode` in 7, `issue_func3` in 3, `issue_func7` in 1, `issue_imm` in DATA_W, `issue_pc` in DATA_W: instruction fields.
- `issue_rs1_busy` in 1, `issue_rs1_tag` in ROB_W, `issue_rs1_val` in DATA_W: operand 1 pending flag, producer tag, value (same set for rs2).
- `cdb_valid` in NUM_CDB: per-channel broadcast valid.
- `cdb_rob_pos` in NUM_CDB*ROB_W and `cdb_val` in NUM_CDB*DATA_W: packed per-channel tag and value, channel 0 in the LSBs.
- `alu_valid` out 1, `alu_ready` in 1: dispatch handshake.
- `alu_opcode`, `alu_func3`, `alu_func7`, `alu_val1`, `alu_val2`, `alu_imm`, `alu_pc`, `alu_rob_pos` out: registered dispatch payload.

## Operation
- Entry state: busy, fields, and per-operand {pending, tag, value}. An entry is ready when busy and both operands are not pending.
- Issue writes the lowest-index free entry. Issuing while no entry is free is a protocol violation; the bench asserts it never happens.
- Issue-cycle capture: if an issued operand is pending and any `cdb_valid[k]` with `cdb_rob_pos[k]` == tag holds in the same cycle, the entry stores the CDB value with pending = 0.
- Wakeup: every busy pending operand whose tag matches a valid channel takes that channel's value and clears pending. Two channels never broadcast the same tag; the lowest channel index wins if they do.
- Selection: among ready entries, choose the minimum age, where age = (rob_pos − rob_head) mod 2^ROB_W. The oldest entry wins, with no ties.
- Load: the output register loads when a ready entry exists and (`!alu_valid` or `alu_ready`). The selected entry frees in the same edge.
- Hold: with `alu_valid && !alu_ready`, the payload stays stable and nothing is selected.
- Free and issue in one cycle: `full` still uses the pre-edge free count, which is conservative by one. The freed slot is reusable the next cycle.
- Reset and rollback do the same thing: all busy = 0, `alu_valid` = 0, payload = 0. `issue` and CDB activity in that cycle are ignored. Rollback takes priority over all else.
- `rdy` low: hold everything, including `alu_valid` and the payload.

## Timing
- Issue at edge t: the entry can be selected at t+1 if ready, and `alu_valid` rises at t+2 at the earliest.
- Wakeup at edge t: selectable at t+1. There is no same-cycle wakeup-to-select path.
- Throughput is one dispatch per cycle while `alu_ready` = 1.
- Reset values: `alu_valid` = 0, all payload outputs = 0, `full` = 0 after reset.

## Structure
- Shared package/`cons.v` holds the opcode/func3 widths, the default `ROB_W`/`DATA_W`, and the age-compare helper function.
- Sub-module `rs_age_select`: parametrised combinational tree taking a ready vector and an age array and returning the oldest valid index plus a found flag. It is reused by the LSB.
- The priority encoder for the free slot stays inline.

## Test plan
- Reset then issue, both operands ready: rob_pos=3, opcode 0110011, val1=5, val2=7 → `alu_valid` at t+2 with val1=5, val2=7, rob_pos=3.
- Pending wakeup: issue rs1 pending tag 6, then a CDB channel 1 broadcast of tag 6 value 0xDEAD → dispatch with val1=0xDEAD exactly 2 cycles after the broadcast.
- Issue-cycle capture: issue rs2 pending tag 2 while cdb[0] broadcasts tag 2 value 9 → dispatch val2=9 without any later broadcast.
- Age order with wrap: rob_head=14, ready entries rob_pos 1 and 15 in slots 0 and 1 → 15 dispatches first, then 1.
- Backpressure and full: DEPTH=4, fill 4 ready entries with `alu_ready` = 0 → `full` = 1, payload stable. Raise `alu_ready` → one dispatch per cycle and `full` drops after the first.
- Rollback mid-operation: 3 busy entries with `alu_valid` = 1 when `rollback` pulses alongside an issue → next cycle `alu_valid` = 0, no entries, the issued entry is discarded, and `full` = 0.
